// File: rtl/data_mem_ctrl.sv
// Load/store data-port responder: sequences one request at a time as byte-serial
// transfers on the shared memory bus, returning extended load results.
module data_mem_ctrl #(
    parameter logic [1:0] IO_TAG = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        need_data,
    input  logic        is_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic [2:0]  work_type,
    output logic        data_handle,
    output logic        data_ready,
    output logic [31:0] data_out,
    output logic        mem_req,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  type_q;
    logic [2:0]  cnt;
    logic        started;
    logic        rd_pend;
    logic [1:0]  rd_lane;
    logic [31:0] ld_buf;

    logic [2:0]  size_n;
    logic        issue;
    logic        last_capture;
    logic [31:0] lane_word;
    logic [31:0] ext_word;
    logic        io_stall;

    always_comb begin
        case (type_q[1:0])
            2'b00:   size_n = 3'd1;
            2'b01:   size_n = 3'd2;
            default: size_n = 3'd4;
        endcase
    end

    // Incoming byte merged into the partially assembled load word
    always_comb begin
        lane_word = ld_buf;
        lane_word[{rd_lane, 3'b000} +: 8] = mem_din;
        case (type_q[1:0])
            2'b00:   ext_word = type_q[2] ? {24'h0, lane_word[7:0]}
                                          : {{24{lane_word[7]}}, lane_word[7:0]};
            2'b01:   ext_word = type_q[2] ? {16'h0, lane_word[15:0]}
                                          : {{16{lane_word[15]}}, lane_word[15:0]};
            default: ext_word = lane_word;
        endcase
    end

    assign io_stall     = (addr_q[17:16] == IO_TAG) && io_buffer_full;
    assign last_capture = rd_pend && ({1'b0, rd_lane} == size_n - 3'd1);

    always_comb begin
        state_n     = state;
        data_handle = 1'b0;
        data_ready  = 1'b0;
        mem_req     = 1'b0;
        mem_a       = 32'h0;
        mem_dout    = 8'h0;
        mem_wr      = 1'b0;
        issue       = 1'b0;
        case (state)
            IDLE: begin
                data_handle = rdy_in && need_data && !rob_clear;
                if (data_handle)
                    state_n = is_write ? STORE : LOAD;
            end
            LOAD: begin
                mem_req = 1'b1;
                if ((cnt < size_n) && (started || mem_gnt)) begin
                    issue = 1'b1;
                    mem_a = addr_q + {29'h0, cnt};
                end
                if (rob_clear)
                    state_n = IDLE;
                else if (last_capture)
                    state_n = DONE;
            end
            STORE: begin
                mem_req = 1'b1;
                if ((cnt < size_n) && (started || mem_gnt) && !io_stall) begin
                    issue  = 1'b1;
                    mem_a  = addr_q + {29'h0, cnt};
                    mem_wr = rdy_in;
                    case (cnt[1:0])
                        2'd0:    mem_dout = wdata_q[7:0];
                        2'd1:    mem_dout = wdata_q[15:8];
                        2'd2:    mem_dout = wdata_q[23:16];
                        default: mem_dout = wdata_q[31:24];
                    endcase
                    if (cnt == size_n - 3'd1)
                        state_n = IDLE;
                end
            end
            DONE: begin
                data_ready = rdy_in && !rob_clear;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            type_q   <= 3'h0;
            cnt      <= 3'h0;
            started  <= 1'b0;
            rd_pend  <= 1'b0;
            rd_lane  <= 2'h0;
            ld_buf   <= 32'h0;
            data_out <= 32'h0;
        end else if (rdy_in) begin
            state <= state_n;
            if (data_handle) begin
                addr_q  <= data_addr;
                wdata_q <= data_in;
                type_q  <= work_type;
                ld_buf  <= 32'h0;
            end
            // Grant is only sampled until the first byte; the arbiter holds it afterwards
            if (mem_req && mem_gnt)
                started <= 1'b1;
            if (issue)
                cnt <= cnt + 3'd1;
            rd_pend <= issue && (state == LOAD);
            rd_lane <= cnt[1:0];
            if (rd_pend && (state == LOAD)) begin
                ld_buf <= lane_word;
                if (last_capture)
                    data_out <= ext_word;
            end
            if (state_n == IDLE) begin
                cnt     <= 3'h0;
                started <= 1'b0;
                rd_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with a byte-wide memory model
// that answers reads one cycle after the address.
module tb_data_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        need_data;
    logic        is_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [2:0]  work_type;
    logic        data_handle;
    logic        data_ready;
    logic [31:0] data_out;
    logic        mem_req;
    logic        mem_gnt;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_model [logic [31:0]];

    data_mem_ctrl #(.IO_TAG(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .need_data(need_data), .is_write(is_write), .data_addr(data_addr),
        .data_in(data_in), .work_type(work_type), .data_handle(data_handle),
        .data_ready(data_ready), .data_out(data_out), .mem_req(mem_req),
        .mem_gnt(mem_gnt), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (mem_req && !mem_wr)
            mem_din <= mem_model.exists(mem_a) ? mem_model[mem_a] : 8'h00;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic request(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] t);
        need_data = 1'b1;
        is_write  = wr;
        data_addr = a;
        data_in   = d;
        work_type = t;
    endtask

    task automatic test_reset();
        step();
        rst_in = 1'b1;
        #2;
        checks++; if (data_handle !== 1'b0) begin failures++; $display("FAIL reset_handle got=%b exp=0", data_handle); end
        checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", data_ready); end
        checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if ({mem_a, mem_dout, mem_wr} !== 41'h0) begin failures++; $display("FAIL reset_bus got=%h/%h/%b exp=0", mem_a, mem_dout, mem_wr); end
        step();
        rst_in = 1'b0;
    endtask

    task automatic test_lw();
        logic [31:0] exp_a;
        step();
        request(1'b0, 32'h100, 32'h0, 3'b010);
        #2;
        checks++; if (data_handle !== 1'b1) begin failures++; $display("FAIL lw_handle got=%b exp=1", data_handle); end
        for (int k = 1; k <= 7; k++) begin
            step();
            need_data = 1'b0;
            #2;
            exp_a = (k <= 4) ? 32'h100 + 32'(k - 1) : 32'h0;
            checks++; if (mem_a !== exp_a) begin failures++; $display("FAIL lw_addr cyc=A+%0d got=%h exp=%h", k, mem_a, exp_a); end
            checks++; if (data_handle !== 1'b0) begin failures++; $display("FAIL lw_single_handle cyc=A+%0d got=%b exp=0", k, data_handle); end
            checks++; if (data_ready !== (k == 6)) begin failures++; $display("FAIL lw_ready cyc=A+%0d got=%b exp=%b", k, data_ready, (k == 6)); end
            if (k == 6) begin
                checks++; if (data_out !== 32'h44332211) begin failures++; $display("FAIL lw_data got=%h exp=44332211", data_out); end
            end
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] addrs [3] = '{32'h101, 32'h101, 32'h102};
        logic [2:0]  types [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] exps  [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFE};
        int          sizes [3] = '{1, 1, 2};
        int          got;
        mem_model[32'h101] = 8'h80;
        mem_model[32'h102] = 8'hFE;
        mem_model[32'h103] = 8'hFF;
        for (int v = 0; v < 3; v++) begin
            step();
            request(1'b0, addrs[v], 32'h0, types[v]);
            #2;
            checks++; if (data_handle !== 1'b1) begin failures++; $display("FAIL ext_handle v=%0d got=%b exp=1", v, data_handle); end
            got = -1;
            for (int k = 1; k <= 8; k++) begin
                step();
                need_data = 1'b0;
                #2;
                if (data_ready === 1'b1 && got < 0) begin
                    got = k;
                    checks++; if (data_out !== exps[v]) begin failures++; $display("FAIL ext_data v=%0d got=%h exp=%h", v, data_out, exps[v]); end
                end
            end
            checks++; if (got != sizes[v] + 2) begin failures++; $display("FAIL ext_latency v=%0d got=%0d exp=%0d", v, got, sizes[v] + 2); end
        end
    endtask

    task automatic test_store_half();
        int got;
        step();
        request(1'b1, 32'h200, 32'hDEADBEEF, 3'b001);
        #2;
        checks++; if (data_handle !== 1'b1) begin failures++; $display("FAIL sh_handle got=%b exp=1", data_handle); end
        step();
        need_data = 1'b0;
        #2;
        checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h200, 8'hEF}) begin failures++; $display("FAIL sh_byte0 got=%b/%h/%h exp=1/200/ef", mem_wr, mem_a, mem_dout); end
        step();
        #2;
        checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h201, 8'hBE}) begin failures++; $display("FAIL sh_byte1 got=%b/%h/%h exp=1/201/be", mem_wr, mem_a, mem_dout); end
        checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL sh_ready got=%b exp=0", data_ready); end
        // Back-to-back: LB 0x100 requested in A+3
        step();
        request(1'b0, 32'h100, 32'h0, 3'b000);
        #2;
        checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL sh_wr_after got=%b exp=0", mem_wr); end
        checks++; if (data_handle !== 1'b1) begin failures++; $display("FAIL sh_next_handle got=%b exp=1", data_handle); end
        got = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            need_data = 1'b0;
            #2;
            if (data_ready === 1'b1 && got < 0) begin
                got = k;
                checks++; if (data_out !== 32'h00000011) begin failures++; $display("FAIL b2b_data got=%h exp=00000011", data_out); end
            end
        end
        checks++; if (got != 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", got); end
    endtask

    task automatic test_io_stall();
        step();
        request(1'b1, 32'h30000, 32'h0000005A, 3'b000);
        #2;
        checks++; if (data_handle !== 1'b1) begin failures++; $display("FAIL io_handle got=%b exp=1", data_handle); end
        for (int k = 1; k <= 5; k++) begin
            step();
            need_data      = 1'b0;
            io_buffer_full = (k <= 3);
            #2;
            if (k <= 3) begin
                checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL io_stall cyc=A+%0d got=%b exp=0", k, mem_wr); end
            end else if (k == 4) begin
                checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h5A}) begin failures++; $display("FAIL io_write got=%b/%h/%h exp=1/30000/5a", mem_wr, mem_a, mem_dout); end
            end else begin
                checks++; if ({mem_wr, mem_req} !== 2'b00) begin failures++; $display("FAIL io_done got=%b%b exp=00", mem_wr, mem_req); end
            end
        end
        io_buffer_full = 1'b0;
    endtask

    task automatic test_flush_load();
        mem_model[32'h101] = 8'h22;
        mem_model[32'h102] = 8'h33;
        mem_model[32'h103] = 8'h44;
        step();
        request(1'b0, 32'h100, 32'h0, 3'b010);
        #2;
        checks++; if (data_handle !== 1'b1) begin failures++; $display("FAIL fl_handle got=%b exp=1", data_handle); end
        for (int k = 1; k <= 8; k++) begin
            step();
            need_data = 1'b0;
            rob_clear = (k == 3);
            #2;
            checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL fl_ready cyc=A+%0d got=%b exp=0", k, data_ready); end
            if (k >= 4) begin
                checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fl_mem_req cyc=A+%0d got=%b exp=0", k, mem_req); end
            end
        end
        rob_clear = 1'b0;
    endtask

    task automatic test_flush_store();
        step();
        request(1'b1, 32'h300, 32'h04030201, 3'b010);
        #2;
        checks++; if (data_handle !== 1'b1) begin failures++; $display("FAIL fs_handle got=%b exp=1", data_handle); end
        for (int k = 1; k <= 5; k++) begin
            step();
            need_data = 1'b0;
            rob_clear = (k == 2);
            #2;
            if (k <= 4) begin
                checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h300 + 32'(k - 1), 8'(k)}) begin failures++; $display("FAIL fs_byte cyc=A+%0d got=%b/%h/%h exp=1/%h/%h", k, mem_wr, mem_a, mem_dout, 32'h300 + 32'(k - 1), 8'(k)); end
            end else begin
                checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL fs_end got=%b exp=0", mem_wr); end
            end
        end
        rob_clear = 1'b0;
    endtask

    task automatic test_grant_wait();
        int got;
        step();
        request(1'b0, 32'h100, 32'h0, 3'b000);
        #2;
        checks++; if (data_handle !== 1'b1) begin failures++; $display("FAIL gw_handle got=%b exp=1", data_handle); end
        got = -1;
        for (int k = 1; k <= 7; k++) begin
            step();
            need_data = 1'b0;
            mem_gnt   = (k >= 3);
            #2;
            if (k <= 2) begin
                checks++; if ({mem_req, mem_a} !== {1'b1, 32'h0}) begin failures++; $display("FAIL gw_wait cyc=A+%0d got=%b/%h exp=1/0", k, mem_req, mem_a); end
            end else if (k == 3) begin
                checks++; if ({mem_req, mem_a} !== {1'b1, 32'h100}) begin failures++; $display("FAIL gw_issue got=%b/%h exp=1/100", mem_req, mem_a); end
            end
            if (data_ready === 1'b1 && got < 0) begin
                got = k;
                checks++; if (data_out !== 32'h00000011) begin failures++; $display("FAIL gw_data got=%h exp=00000011", data_out); end
            end
        end
        checks++; if (got != 5) begin failures++; $display("FAIL gw_latency got=%0d exp=5", got); end
    endtask

    task automatic test_clear_block();
        for (int k = 0; k < 4; k++) begin
            step();
            request(1'b0, 32'h100, 32'h0, 3'b010);
            rob_clear = 1'b1;
            #2;
            checks++; if (data_handle !== 1'b0) begin failures++; $display("FAIL cb_handle cyc=%0d got=%b exp=0", k, data_handle); end
            checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cb_mem_req cyc=%0d got=%b exp=0", k, mem_req); end
        end
        step();
        need_data = 1'b0;
        rob_clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; need_data = 1'b0;
        is_write = 1'b0; data_addr = 32'h0; data_in = 32'h0; work_type = 3'b000;
        mem_gnt = 1'b1; io_buffer_full = 1'b0; mem_din = 8'h00;
        mem_model[32'h100] = 8'h11;
        mem_model[32'h101] = 8'h22;
        mem_model[32'h102] = 8'h33;
        mem_model[32'h103] = 8'h44;
        step();
        rst_in = 1'b0;
        step();
        test_reset();
        test_lw();
        test_load_ext();
        test_store_half();
        test_io_stall();
        test_flush_load();
        test_flush_store();
        test_grant_wait();
        test_clear_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Responder on the data port of the load/store buffer. It accepts one load or store request at a time and sequences it as byte-serial transfers on the shared memory bus. Loads are returned with sign or zero extension; stores are fire-and-forget. It sits between the load/store buffer and the top-level memory arbiter, which also serves instruction fetch.

## Interface
- IO_TAG, 2'b11: value of addr[17:16] that marks memory-mapped IO.
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global ready; when low, all state is frozen.
- rob_clear  in  1  pipeline flush.
- need_data  in  1  request valid from the load/store buffer.
- is_write  in  1  1 = store, 0 = load.
- data_addr  in  32  byte address.
- data_in  in  32  store data.
- work_type  in  3  func3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- data_handle  out  1  request accepted this cycle (combinational).
- data_ready  out  1  one-cycle load-complete pulse.
- data_out  out  32  extended load result, valid while data_ready is high.
- mem_req  out  1  bus request to the arbiter.
- mem_gnt  in  1  bus grant.
- mem_din  in  8  read byte, valid one cycle after its address.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write strobe.
- io_buffer_full  in  1  IO sink cannot accept a byte.

## Operation
- States: IDLE, LOAD, STORE, DONE.
- **IDLE**
  - data_handle = rdy_in && need_data && !rob_clear && state==IDLE.
  - On handle, latch addr, data, type and direction; size n = 1 / 2 / 4 from work_type[1:0] (00, 01, 10); 11 is treated as 4.
  - Go to LOAD or STORE. No request is ever accepted outside IDLE.
- **mem_req** is high in LOAD and STORE.
  - No byte is issued until mem_gnt is seen high.
  - Once the first byte is issued, the arbiter holds mem_gnt until mem_req falls; the block does not re-check it.
- **LOAD**
  - Issue byte i at mem_a = addr+i (32-bit wrap) with mem_wr=0, one byte per cycle, i = 0..n-1.
  - Capture mem_din the following cycle into byte lane i.
  - After capturing byte n-1, register data_out:
    - work_type[2]=0: sign-extend from bit 8n-1.
    - work_type[2]=1: zero-extend.
  - Go to DONE.
- **DONE**: data_ready=1 for exactly one cycle, then IDLE.
- **STORE**
  - Issue byte i with mem_a = addr+i, mem_dout = data[8i+7:8i], mem_wr=1.
  - If addr[17:16]==IO_TAG and io_buffer_full=1, stall that byte: mem_wr=0 and the counter holds.
  - After byte n-1, return to IDLE. data_ready is never pulsed for stores; the buffer retires the store on data_handle.
- **rob_clear**
  - In LOAD or DONE: abort and go to IDLE at the next edge. data_ready stays 0, including the cycle of the clear.
  - In STORE: ignored; all n bytes complete, because the store was already committed.
  - In IDLE: blocks acceptance.
- **Bus defaults**: when no byte is being issued, mem_wr=0, mem_a=0 and mem_dout=0. mem_wr is also forced to 0 while rdy_in is low.
- Misaligned addresses are legal, since all transfers are byte-serial.

## Timing
- Reset (asynchronous) puts the block in IDLE. All outputs are 0: data_handle, data_ready, data_out, mem_req, mem_dout, mem_a, mem_wr. Byte counter and latches are cleared.
- With A = the handle cycle and grant already high:
  - Bytes are issued in cycles A+1 .. A+n.
  - The last read byte appears in cycle A+n+1.
  - data_ready is high in cycle A+n+2; a load word therefore completes at A+6.
- Store: bytes are written in A+1 .. A+n; the earliest next handle is A+n+1, assuming no stalls.
- Load: the earliest next handle is A+n+3.
- Each cycle mem_gnt is low before the first issue adds one cycle.
- Each cycle of IO back-pressure adds one cycle.
- data_handle is high in exactly one cycle per transaction.

## Test plan
- LW at 0x100, memory holding 11,22,33,44: data_handle in A only, mem_a = 0x100..0x103 in A+1..A+4, data_ready in A+6 with data_out = 0x44332211.
- LB at 0x101 (byte 0x80) returns 0xFFFFFF80. LBU at the same address returns 0x00000080. LH at 0x102 with bytes 0xFE,0xFF returns 0xFFFFFFFE.
- SH at 0x200 with data 0xDEADBEEF: writes 0xEF@0x200 in A+1 and 0xBE@0x201 in A+2 with mem_wr=1. mem_wr=0 in A+3, data_ready is never high, and a new handle is possible in A+3.
- SB to 0x30000 with io_buffer_full high for A+1..A+3: mem_wr=0 in those cycles, and the write of the byte occurs in A+4.
- rob_clear in A+3 of an LW: no data_ready, mem_req=0 and state IDLE from A+4. rob_clear in A+2 of an SW: all four bytes are still written.
- mem_gnt low for A+1..A+2 after a handle: mem_req=1 with no issue in those cycles; byte 0 is issued in A+3. A request held with rob_clear=1 is never handled.
